nibble_serial_alu_ctrl: RTL and testbench
=========================================

Name: nibble_serial_alu_ctrl

Overview:
Multi-cycle controller that runs wide-operand ALU operations through a single shared 4-bit ALU slice, one nibble per clock, least significant nibble first. It latches the operands and opcode, sequences the nibbles while carrying between them, assembles the result and flags, and returns them over a valid/ready handshake. It sits between the lab datapath register file and the 4-bit combinational ALU slice, trading latency for area.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES (default 16). Legal range 2..8.

Ports:
clk  input  1  system clock, all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  request presents a_in, b_in and op
in_ready  output  1  controller can accept a request (high only in IDLE)
a_in  input  W  operand A
b_in  input  W  operand B
op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOR, 110 PASS_A, 111 PASS_B
out_valid  output  1  result and flags are valid (high only in DONE)
out_ready  input  1  consumer accepts the result
result  output  W  assembled result
flag_c  output  1  carry out of the MSB (ADD/SUB); 0 for logic ops
flag_z  output  1  result == 0
flag_v  output  1  signed overflow (ADD/SUB); 0 for logic ops
flag_n  output  1  result[W-1]
busy  output  1  high in RUN

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high on rst.
- Reset drives state to IDLE and clears result, all flags, nibble index, carry and the latched operands and opcode to 0. Outputs during and after reset: in_ready=1, out_valid=0, busy=0.
- State machine states are IDLE, RUN and DONE.
- IDLE: in_ready=1. On the edge where in_valid & in_ready, the block:
  - latches a_in, b_in and op;
  - clears result and index;
  - sets carry = (op==SUB);
  - moves to RUN.
  - in_valid while not in IDLE is ignored. There is no queue.
- RUN: each cycle the slice gets A nibble[idx], B nibble[idx] (inverted for SUB), carry and op.
  - Slice output is written to result[4*idx+3:4*idx].
  - carry <= slice carry-out, but only for ADD/SUB.
  - idx increments each cycle.
  - The cycle with idx==NIBBLES-1 computes the flags and moves to DONE.
  - RUN lasts exactly NIBBLES cycles.
- Latency: if the request is accepted at edge k, out_valid goes high after edge k+NIBBLES.
- DONE: out_valid=1. result and flags are held stable until out_valid & out_ready, then the block returns to IDLE.
  - Back-to-back operation: a new request is accepted no earlier than the edge after the handshake. Throughput is one operation per NIBBLES+2 cycles minimum.
- Arithmetic rules:
  - ADD computes A+B.
  - SUB computes A+~B+1. flag_c=1 means no borrow.
  - flag_v = (A[W-1]==B'[W-1]) && (result[W-1]!=A[W-1]), where B' = B for ADD and ~B for SUB.
  - Logic ops: flag_c=0 and flag_v=0.
  - NOR is the bitwise ~(A|B).
  - All widths are modulo W; there is no saturation.
- result and flags do not change outside RUN. They keep their last values while in IDLE.
- Reset asserted mid-RUN or in DONE aborts the operation immediately. The partial result is discarded (cleared to 0), and no out_valid follows.
- out_ready high while not in DONE has no effect.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_ADD..OP_PASS_B;
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
- Sub-module alu_nibble: purely combinational 4-bit slice, inputs a[3:0], b[3:0], cin, op[2:0], outputs d[3:0], cout. It is instantiated once and time-shared by the controller.
- The controller holds the FSM, the index counter, the carry flop, the operand registers and the result/flag registers.

Test Plan:
- ADD a_in=0x7FFF, b_in=0x0001 -> after 4 cycles, result=0x8000, C=0, Z=0, V=1, N=1. out_valid rises exactly 4 edges after acceptance.
- ADD 0xFFFF + 0x0001 -> result=0x0000, C=1, Z=1, V=0, N=0. SUB 0x0005 - 0x0005 -> 0x0000, C=1, Z=1. SUB 0x0003 - 0x0005 -> 0xFFFE, C=0, N=1, V=0.
- NOR 0x0F0F, 0x00FF -> 0xF000, N=1, C=0, V=0. PASS_B with b_in=0x1234 -> 0x1234. XOR 0xAAAA, 0xFFFF -> 0x5555.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> result and flags stable, in_ready=0. A new in_valid pulse in that window is ignored. Raising out_ready gives IDLE next cycle, and the following request is accepted.
- Reset mid-RUN (assert rst after 2 nibbles) -> same cycle result=0, flags=0, busy=0, in_ready=1. No out_valid ever follows for that operation.
- Back-to-back: keep in_valid=1 with out_ready=1 for 3 requests -> exactly 3 out_valid pulses, each one cycle wide, spaced NIBBLES+2 cycles apart, with results in order.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Opcodes, FSM state type and helpers shared by the nibble ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_AND    = 3'b010;
    localparam logic [2:0] OP_OR     = 3'b011;
    localparam logic [2:0] OP_XOR    = 3'b100;
    localparam logic [2:0] OP_NOR    = 3'b101;
    localparam logic [2:0] OP_PASS_A = 3'b110;
    localparam logic [2:0] OP_PASS_B = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_nibble.sv
// ============================================================================
// Module      : alu_nibble
// Description : Combinational 4-bit ALU slice, time-shared by the controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_nibble
    import alu_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic [2:0] op,
    output logic [3:0] d,
    output logic       cout
);

    logic [4:0] w_sum;

    // SUB arrives with b already inverted and cin=1, so it shares the adder with ADD.
    assign w_sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

    always_comb begin
        d    = 4'h0;
        cout = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                d    = w_sum[3:0];
                cout = w_sum[4];
            end
            OP_AND:    d = a & b;
            OP_OR:     d = a | b;
            OP_XOR:    d = a ^ b;
            OP_NOR:    d = ~(a | b);
            OP_PASS_A: d = a;
            OP_PASS_B: d = b;
            default:   d = 4'h0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/nibble_serial_alu_ctrl.sv
// ============================================================================
// Module      : nibble_serial_alu_ctrl
// Description : Runs W-bit ALU operations one nibble per clock through a shared
//               4-bit slice, LSB nibble first, with valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_serial_alu_ctrl
    import alu_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a_in,
    input  logic [4*NIBBLES-1:0]   b_in,
    input  logic [2:0]             op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   flag_c,
    output logic                   flag_z,
    output logic                   flag_v,
    output logic                   flag_n,
    output logic                   busy
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [2:0]         r_op;
    logic [W-1:0]       r_result;
    logic               r_c;
    logic               r_z;
    logic               r_v;
    logic               r_n;

    logic               w_accept;
    logic               w_last;
    logic               w_arith;
    logic               w_is_sub;
    logic [3:0]         w_a_nib;
    logic [3:0]         w_b_nib;
    logic [3:0]         w_d;
    logic               w_cout;
    logic [W-1:0]       w_result_next;
    logic               w_bp_msb;
    logic               w_ovf;

    assign w_accept = (r_state == ST_IDLE) && in_valid;
    assign w_last   = (r_idx == C_LAST_IDX);
    assign w_arith  = is_arith(r_op);
    assign w_is_sub = (r_op == OP_SUB);
    assign w_a_nib  = r_a[4*r_idx +: 4];
    assign w_b_nib  = w_is_sub ? ~r_b[4*r_idx +: 4] : r_b[4*r_idx +: 4];

    alu_nibble u_slice (
        .a    (w_a_nib),
        .b    (w_b_nib),
        .cin  (r_carry),
        .op   (r_op),
        .d    (w_d),
        .cout (w_cout)
    );

    always_comb begin
        w_result_next = r_result;
        w_result_next[4*r_idx +: 4] = w_d;
    end

    // Overflow uses the effective B operand, i.e. ~B for SUB.
    assign w_bp_msb = w_is_sub ? ~r_b[W-1] : r_b[W-1];
    assign w_ovf    = w_arith && (r_a[W-1] == w_bp_msb) &&
                      (w_result_next[W-1] != r_a[W-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 3'b000;
            r_result <= '0;
            r_c      <= 1'b0;
            r_z      <= 1'b0;
            r_v      <= 1'b0;
            r_n      <= 1'b0;
        end else if (w_accept) begin
            r_a      <= a_in;
            r_b      <= b_in;
            r_op     <= op;
            r_result <= '0;
            r_idx    <= '0;
            r_carry  <= (op == OP_SUB);
        end else if (r_state == ST_RUN) begin
            r_result <= w_result_next;
            r_idx    <= r_idx + 1'b1;
            if (w_arith) r_carry <= w_cout;
            if (w_last) begin
                r_c <= w_arith & w_cout;
                r_z <= (w_result_next == '0);
                r_v <= w_ovf;
                r_n <= w_result_next[W-1];
            end
        end
    end

    assign result = r_result;
    assign flag_c = r_c;
    assign flag_z = r_z;
    assign flag_v = r_v;
    assign flag_n = r_n;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_alu_ctrl.sv
// ============================================================================
// Module      : tb_nibble_serial_alu_ctrl
// Description : Randomised and directed checks of the nibble-serial ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_serial_alu_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   a_in = '0;
    logic [W-1:0]   b_in = '0;
    logic [2:0]     op = 3'b000;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   result;
    logic           flag_c, flag_z, flag_v, flag_n;
    logic           busy;

    int n_vec = 0;
    int n_err = 0;

    nibble_serial_alu_ctrl #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .flag_v    (flag_v),
        .flag_n    (flag_n),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Whole-word reference: {result, C, Z, V, N}
    function automatic logic [W+3:0] model(input logic [2:0] o, input logic [W-1:0] a, b);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic [W-1:0] bp;
        logic         c, v;
        c = 1'b0; v = 1'b0; bp = b; s = '0;
        case (o)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; end
            3'd1: begin bp = ~b; s = {1'b0, a} + {1'b0, bp} + 1; end
            default: s = '0;
        endcase
        case (o)
            3'd0, 3'd1: begin
                r = s[W-1:0];
                c = s[W];
                v = (a[W-1] == bp[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~(a | b);
            3'd6: r = a;
            default: r = b;
        endcase
        return {r, c, (r == '0), v, r[W-1]};
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, b,
                          input int hold, input bit poke);
        logic [W+3:0] exp_v;
        int j;
        exp_v = model(o, a, b);
        @(negedge clk);
        in_valid = 1'b1; op = o; a_in = a; b_in = b;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL accept_ready: in_ready=%b expected 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; a_in = W'($urandom); b_in = W'($urandom); op = 3'($urandom);
        n_vec++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL run_busy: busy=%b in_ready=%b expected 1/0", busy, in_ready);
        end
        j = 0;
        while (out_valid !== 1'b1 && j < 4 * N) begin
            @(posedge clk); j++; @(negedge clk);
        end
        n_vec++;
        if (j != N) begin
            n_err++; $display("FAIL latency: out_valid after %0d edges expected %0d", j, N);
        end
        n_vec++;
        if ({result, flag_c, flag_z, flag_v, flag_n} !== exp_v) begin
            n_err++;
            $display("FAIL result op=%0d a=%h b=%h: got %h CZVN=%b%b%b%b expected %h CZVN=%b",
                     o, a, b, result, flag_c, flag_z, flag_v, flag_n, exp_v[W+3:4], exp_v[3:0]);
        end
        for (int k = 0; k < hold; k++) begin
            in_valid = poke && (k == 1);
            @(posedge clk); @(negedge clk);
            in_valid = 1'b0;
            n_vec++;
            if ({result, flag_c, flag_z, flag_v, flag_n} !== exp_v || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL hold: result=%h flags=%b ov=%b ir=%b expected %h %b 1 0",
                         result, {flag_c, flag_z, flag_v, flag_n}, out_valid, in_ready, exp_v[W+3:4], exp_v[3:0]);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || {result, flag_c, flag_z, flag_v, flag_n} !== exp_v) begin
            n_err++;
            $display("FAIL idle_after_hs: ov=%b ir=%b result=%h expected 0 1 %h", out_valid, in_ready, result, exp_v[W+3:4]);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== '0 ||
            {flag_c, flag_z, flag_v, flag_n} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset: ir=%b ov=%b busy=%b result=%h flags=%b expected 1 0 0 0 0000",
                     in_ready, out_valid, busy, result, {flag_c, flag_z, flag_v, flag_n});
        end
        rst = 1'b0;
    endtask

    task automatic test_directed;
        run_op(3'd0, 16'h7FFF, 16'h0001, 0, 1'b0);
        run_op(3'd0, 16'hFFFF, 16'h0001, 0, 1'b0);
        run_op(3'd1, 16'h0005, 16'h0005, 0, 1'b0);
        run_op(3'd1, 16'h0003, 16'h0005, 0, 1'b0);
        run_op(3'd5, 16'h0F0F, 16'h00FF, 0, 1'b0);
        run_op(3'd7, 16'hBEEF, 16'h1234, 0, 1'b0);
        run_op(3'd4, 16'hAAAA, 16'hFFFF, 0, 1'b0);
        run_op(3'd1, 16'h8000, 16'h0001, 0, 1'b0);
    endtask

    task automatic test_random;
        logic [W-1:0] corner [4];
        logic [W-1:0] a, b;
        corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h8000; corner[3] = 16'h7FFF;
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            run_op(3'($urandom_range(0, 7)), a, b, $urandom_range(0, 2), 1'b0);
        end
    endtask

    task automatic test_backpressure;
        run_op(3'd0, 16'h1234, 16'h4321, 3, 1'b1);
        run_op(3'd2, 16'hF0F0, 16'h3C3C, 0, 1'b0);
    endtask

    task automatic test_reset_mid_run;
        bit seen;
        @(negedge clk);
        in_valid = 1'b1; op = 3'd0; a_in = 16'hFFFF; b_in = 16'h0FFF;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if (result !== '0 || {flag_c, flag_z, flag_v, flag_n} !== 4'b0000 || busy !== 1'b0 ||
            in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_run: result=%h flags=%b busy=%b ir=%b ov=%b expected 0 0000 0 1 0",
                     result, {flag_c, flag_z, flag_v, flag_n}, busy, in_ready, out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (3 * N) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_err++; $display("FAIL abort_no_valid: out_valid seen=1 expected 0");
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0]   ops [3];
        logic [W-1:0] as [3];
        logic [W-1:0] bs [3];
        logic [W+3:0] exp_v;
        int acc, pulses, last_cyc;
        bit take;
        for (int i = 0; i < 3; i++) begin
            ops[i] = 3'($urandom_range(0, 7)); as[i] = W'($urandom); bs[i] = W'($urandom);
        end
        acc = 0; pulses = 0; last_cyc = -1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 4 * (N + 2) + 8; cyc++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                exp_v = (pulses < 3) ? model(ops[pulses], as[pulses], bs[pulses]) : '0;
                n_vec++;
                if (pulses >= 3 || {result, flag_c, flag_z, flag_v, flag_n} !== exp_v) begin
                    n_err++;
                    $display("FAIL b2b_result #%0d: got %h flags=%b expected %h flags=%b",
                             pulses, result, {flag_c, flag_z, flag_v, flag_n}, exp_v[W+3:4], exp_v[3:0]);
                end
                if (last_cyc >= 0) begin
                    n_vec++;
                    if (cyc - last_cyc != N + 2) begin
                        n_err++; $display("FAIL b2b_spacing: %0d cycles expected %0d", cyc - last_cyc, N + 2);
                    end
                end
                last_cyc = cyc;
                pulses++;
            end
            if (acc < 3) begin
                in_valid = 1'b1; op = ops[acc]; a_in = as[acc]; b_in = bs[acc];
            end else begin
                in_valid = 1'b0;
            end
            take = in_valid && (in_ready === 1'b1);
            @(posedge clk);
            if (take) acc++;
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        n_vec++;
        if (pulses != 3) begin
            n_err++; $display("FAIL b2b_count: %0d pulses expected 3", pulses);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_backpressure;
        test_reset_mid_run;
        test_random;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
